// File: rtl/ddr2_calib_seq_0_pkg.sv
// Shared DDR2 read-calibration definitions: FSM state encodings, default
// sequencing parameters and counter widths.
package ddr2_calib_seq_0_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_DQS_PRE = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_WR2RD   = 3'd4,
    ST_RD_CAL  = 3'd5,
    ST_DONE    = 3'd6,
    ST_FAIL    = 3'd7
  } cal_state_e;

  localparam int unsigned DEF_WR_BURSTS   = 4;
  localparam int unsigned DEF_WAIT_WR2RD  = 16;
  localparam int unsigned DEF_CAL_TIMEOUT = 1023;
  localparam int unsigned DEF_MAX_RETRY   = 3;

  localparam int BURST_W = 4;
  localparam int WAIT_W  = 8;
  localparam int TMO_W   = 10;
  localparam int RETRY_W = 2;

  typedef struct packed {
    logic wr_cmd_req;
    logic dummy_wr_sel;
    logic wren;
    logic dqs_rst;
    logic dqs_en;
    logic dummyread_start;
    logic calib_done;
    logic calib_fail;
  } cal_out_t;

endpackage

// File: rtl/ddr2_cycle_cnt_0.sv
// Loadable down counter; expired_o is high while the count sits at zero, so a
// load of N-1 gives a window of exactly N enabled cycles.
module ddr2_cycle_cnt_0 #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ddr2_calib_seq_0.sv
// DDR2 read-calibration sequencer: dummy-write bursts, write-to-read gap, then
// dummy-read calibration with timeout and retry. All outputs are Moore/registered.
module ddr2_calib_seq_0
  import ddr2_calib_seq_0_pkg::*;
#(
  parameter int unsigned WR_BURSTS   = DEF_WR_BURSTS,
  parameter int unsigned WAIT_WR2RD  = DEF_WAIT_WR2RD,
  parameter int unsigned CAL_TIMEOUT = DEF_CAL_TIMEOUT,
  parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic       clk_i,
  input  logic       reset0_i,
  input  logic       init_done_i,
  input  logic       wr_cmd_ack_i,
  input  logic       sel_done_i,
  output logic       wr_cmd_req_o,
  output logic       ctrl_dummy_wr_sel_o,
  output logic       ctrl_wren_o,
  output logic       ctrl_dqs_rst_o,
  output logic       ctrl_dqs_en_o,
  output logic       ctrl_dummyread_start_o,
  output logic       calib_done_o,
  output logic       calib_fail_o,
  output logic [1:0] dbg_retry_cnt_o,
  output logic [2:0] dbg_state_o
);

  localparam logic [BURST_W-1:0] BURSTS    = BURST_W'(WR_BURSTS);
  localparam logic [WAIT_W-1:0]  WAIT_LOAD = WAIT_W'(WAIT_WR2RD - 1);
  localparam logic [TMO_W-1:0]   TMO_LOAD  = TMO_W'(CAL_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  cal_state_e         state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               beat_q, beat_d;
  cal_out_t           out_q, out_d;

  logic cnt_clr;
  logic wait_load, wait_exp;
  logic tmo_load, tmo_exp;

  ddr2_cycle_cnt_0 #(.W(WAIT_W)) u_wait_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (reset0_i),
    .clr_i      (cnt_clr),
    .load_i     (wait_load),
    .load_val_i (WAIT_LOAD),
    .en_i       (state_q == ST_WR2RD),
    .expired_o  (wait_exp)
  );

  ddr2_cycle_cnt_0 #(.W(TMO_W)) u_tmo_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (reset0_i),
    .clr_i      (cnt_clr),
    .load_i     (tmo_load),
    .load_val_i (TMO_LOAD),
    .en_i       (state_q == ST_RD_CAL),
    .expired_o  (tmo_exp)
  );

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    retry_d   = retry_q;
    beat_d    = 1'b0;
    cnt_clr   = 1'b0;
    wait_load = 1'b0;
    tmo_load  = 1'b0;

    // Dropping init_done abandons whatever is in flight, from any state.
    if (!init_done_i) begin
      state_d = ST_IDLE;
      burst_d = '0;
      retry_d = '0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_WR_REQ;
          burst_d = '0;
        end
        ST_WR_REQ: begin
          if (wr_cmd_ack_i) state_d = ST_DQS_PRE;
        end
        ST_DQS_PRE: state_d = ST_WR_DATA;
        ST_WR_DATA: begin
          if (!beat_q) begin
            beat_d = 1'b1;
          end else begin
            burst_d = (burst_q == '1) ? burst_q : burst_q + 1'b1;
            if (burst_d < BURSTS) begin
              state_d = ST_WR_REQ;
            end else begin
              state_d   = ST_WR2RD;
              wait_load = 1'b1;
            end
          end
        end
        ST_WR2RD: begin
          if (wait_exp) begin
            state_d  = ST_RD_CAL;
            tmo_load = 1'b1;
          end
        end
        ST_RD_CAL: begin
          // sel_done takes priority over a timeout landing on the same cycle.
          if (sel_done_i) begin
            state_d = ST_DONE;
          end else if (tmo_exp) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              burst_d = '0;
              state_d = ST_WR_REQ;
            end else begin
              state_d = ST_FAIL;
            end
          end
        end
        ST_DONE: state_d = ST_DONE;
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase
    end

    out_d                 = '0;
    out_d.wr_cmd_req      = (state_d == ST_WR_REQ);
    out_d.dummy_wr_sel    = (state_d == ST_WR_REQ) || (state_d == ST_DQS_PRE) ||
                            (state_d == ST_WR_DATA);
    out_d.wren            = (state_d == ST_WR_DATA);
    out_d.dqs_rst         = (state_d == ST_DQS_PRE);
    out_d.dqs_en          = (state_d == ST_DQS_PRE) || (state_d == ST_WR_DATA);
    out_d.dummyread_start = (state_d == ST_RD_CAL);
    out_d.calib_done      = (state_d == ST_DONE);
    out_d.calib_fail      = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_i) begin
    if (!reset0_i) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
      retry_q <= '0;
      beat_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      retry_q <= retry_d;
      beat_q  <= beat_d;
      out_q   <= out_d;
    end
  end

  assign wr_cmd_req_o           = out_q.wr_cmd_req;
  assign ctrl_dummy_wr_sel_o    = out_q.dummy_wr_sel;
  assign ctrl_wren_o            = out_q.wren;
  assign ctrl_dqs_rst_o         = out_q.dqs_rst;
  assign ctrl_dqs_en_o          = out_q.dqs_en;
  assign ctrl_dummyread_start_o = out_q.dummyread_start;
  assign calib_done_o           = out_q.calib_done;
  assign calib_fail_o           = out_q.calib_fail;
  assign dbg_retry_cnt_o        = retry_q;
  assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_ddr2_calib_seq_0.sv
// Bench for ddr2_calib_seq_0: builds a cycle-by-cycle timeline of stimulus and
// expected outputs from the sequencing rules, then replays it against the DUT.
module tb_ddr2_calib_seq_0;
  import ddr2_calib_seq_0_pkg::*;

  localparam int WR_BURSTS   = DEF_WR_BURSTS;
  localparam int WAIT_WR2RD  = DEF_WAIT_WR2RD;
  localparam int CAL_TIMEOUT = DEF_CAL_TIMEOUT;
  localparam int MAX_RETRY   = DEF_MAX_RETRY;
  localparam int OW          = 13;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset0, init_done, wr_cmd_ack, sel_done;
  logic       wr_cmd_req, dummy_wr_sel, wren, dqs_rst, dqs_en, dummyread_start;
  logic       calib_done, calib_fail;
  logic [1:0] dbg_retry_cnt;
  logic [2:0] dbg_state;

  ddr2_calib_seq_0 #(
    .WR_BURSTS   (WR_BURSTS),
    .WAIT_WR2RD  (WAIT_WR2RD),
    .CAL_TIMEOUT (CAL_TIMEOUT),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk_i                  (clk),
    .reset0_i               (reset0),
    .init_done_i            (init_done),
    .wr_cmd_ack_i           (wr_cmd_ack),
    .sel_done_i             (sel_done),
    .wr_cmd_req_o           (wr_cmd_req),
    .ctrl_dummy_wr_sel_o    (dummy_wr_sel),
    .ctrl_wren_o            (wren),
    .ctrl_dqs_rst_o         (dqs_rst),
    .ctrl_dqs_en_o          (dqs_en),
    .ctrl_dummyread_start_o (dummyread_start),
    .calib_done_o           (calib_done),
    .calib_fail_o           (calib_fail),
    .dbg_retry_cnt_o        (dbg_retry_cnt),
    .dbg_state_o            (dbg_state)
  );

  // scoreboard: expected outputs per cycle, stimulus {rst_n, init, ack, sel} per cycle
  logic [OW-1:0] exp_q[$];
  logic [3:0]    stim_q[$];
  int            run_start;
  int            checks = 0;
  int            errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Outputs expected while sitting in a given state.
  function automatic logic [OW-1:0] mk(input logic [2:0] st, input int retry);
    logic [31:0] r;
    logic req, dws, wr, drst, den, drs, dn, fl;
    r    = retry;
    req  = (st == ST_WR_REQ);
    dws  = (st == ST_WR_REQ) || (st == ST_DQS_PRE) || (st == ST_WR_DATA);
    wr   = (st == ST_WR_DATA);
    drst = (st == ST_DQS_PRE);
    den  = (st == ST_DQS_PRE) || (st == ST_WR_DATA);
    drs  = (st == ST_RD_CAL);
    dn   = (st == ST_DONE);
    fl   = (st == ST_FAIL);
    return {req, dws, wr, drst, den, drs, dn, fl, r[1:0], st};
  endfunction

  function automatic bit noise();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic push(input logic [OW-1:0] e, input bit rst_n, input bit init,
                      input bit ack, input bit sel);
    exp_q.push_back(e);
    stim_q.push_back({rst_n, init, ack, sel});
  endtask

  // One calibration run from IDLE with init_done high; sel_at[a] is the
  // RD_CAL cycle (0-based) of attempt a where sel_done rises, -1 for never.
  task automatic build_run(input int s0, input int s1, input int s2, input int s3);
    int sel_at[4];
    int d;
    sel_at[0] = s0; sel_at[1] = s1; sel_at[2] = s2; sel_at[3] = s3;
    run_start = exp_q.size();
    push(mk(ST_IDLE, 0), 1, 1, noise(), noise());
    for (int a = 0; a <= MAX_RETRY; a++) begin
      for (int b = 0; b < WR_BURSTS; b++) begin
        d = $urandom_range(0, 3);
        for (int i = 0; i <= d; i++) push(mk(ST_WR_REQ, a), 1, 1, (i == d), noise());
        push(mk(ST_DQS_PRE, a), 1, 1, noise(), noise());
        for (int i = 0; i < 2; i++) push(mk(ST_WR_DATA, a), 1, 1, noise(), noise());
      end
      for (int i = 0; i < WAIT_WR2RD; i++) push(mk(ST_WR2RD, a), 1, 1, noise(), noise());
      if (sel_at[a] >= 0) begin
        for (int i = 0; i < sel_at[a]; i++) push(mk(ST_RD_CAL, a), 1, 1, noise(), 0);
        push(mk(ST_RD_CAL, a), 1, 1, noise(), 1);
        for (int i = 0; i < 5; i++) push(mk(ST_DONE, a), 1, 1, noise(), noise());
        return;
      end
      for (int i = 0; i < CAL_TIMEOUT; i++) push(mk(ST_RD_CAL, a), 1, 1, noise(), 0);
    end
    for (int i = 0; i < 5; i++) push(mk(ST_FAIL, MAX_RETRY), 1, 1, noise(), noise());
  endtask

  // Cut the timeline at cycle j by dropping init_done (or reset0) there;
  // the sequencer is back in IDLE with everything cleared one edge later.
  task automatic abort_at(input int j, input bit by_reset);
    logic [3:0] s;
    while (exp_q.size() > j + 1) begin
      void'(exp_q.pop_back());
      void'(stim_q.pop_back());
    end
    s = stim_q[j];
    if (by_reset) s[3] = 1'b0;
    else          s[2] = 1'b0;
    stim_q[j] = s;
    for (int k = 0; k < 4; k++) push(mk(ST_IDLE, 0), 1, 0, (k % 2 == 0), noise());
  endtask

  function automatic int find_state(input int from, input logic [2:0] st, input int nth);
    int n;
    n = 0;
    for (int i = from; i < exp_q.size(); i++) begin
      if (exp_q[i][2:0] == st) begin
        if (n == nth) return i;
        n++;
      end
    end
    return -1;
  endfunction

  function automatic int pick_sel();
    if ($urandom_range(0, 2) == 0) return -1;
    return $urandom_range(0, CAL_TIMEOUT - 1);
  endfunction

  task automatic build_all();
    int j;
    push(mk(ST_IDLE, 0), 0, 0, 0, 0);
    push(mk(ST_IDLE, 0), 1, 0, 1, 0);
    push(mk(ST_IDLE, 0), 1, 0, 0, 0);
    // nominal pass
    build_run(50, -1, -1, -1);
    abort_at(exp_q.size() - 1, 0);
    // never selected: four timeouts then FAIL
    build_run(-1, -1, -1, -1);
    abort_at(exp_q.size() - 1, 0);
    // timeout then pass on the retry
    build_run(-1, 30, -1, -1);
    abort_at(exp_q.size() - 1, 0);
    // sel_done on the exact expiry cycle
    build_run(CAL_TIMEOUT - 1, -1, -1, -1);
    abort_at(exp_q.size() - 1, 0);
    // init_done dropped in the middle of a write burst, then a clean restart
    build_run(100, -1, -1, -1);
    j = find_state(run_start, ST_WR_DATA, $urandom_range(0, 2 * WR_BURSTS - 1));
    abort_at(j, 0);
    build_run(20, -1, -1, -1);
    abort_at(exp_q.size() - 1, 0);
    // reset during the second attempt's RD_CAL
    build_run(-1, 400, -1, -1);
    j = find_state(run_start, ST_RD_CAL, CAL_TIMEOUT + 100);
    abort_at(j, 1);
    for (int r = 0; r < 4; r++) begin
      build_run(pick_sel(), pick_sel(), pick_sel(), pick_sel());
      abort_at(exp_q.size() - 1, 0);
    end
  endtask

  initial begin
    logic [OW-1:0] obs;
    reset0     = 1'b0;
    init_done  = 1'b0;
    wr_cmd_ack = 1'b0;
    sel_done   = 1'b0;
    build_all();
    // driver + checker: cycle t spans edge t to edge t+1
    for (int t = 0; t < exp_q.size(); t++) begin
      @(posedge clk);
      #1;
      {reset0, init_done, wr_cmd_ack, sel_done} = stim_q[t];
      @(negedge clk);
      obs = {wr_cmd_req, dummy_wr_sel, wren, dqs_rst, dqs_en, dummyread_start,
             calib_done, calib_fail, dbg_retry_cnt, dbg_state};
      check_eq($sformatf("cycle%0d", t), 32'(obs), 32'(exp_q[t]));
      check_eq($sformatf("excl%0d", t), 32'(calib_done & calib_fail), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
